// File: rtl/mul_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_pkg: shared operation codes, core latency and high-word correction.     |
// | Optional feature macro: MUL_UNSIGNED_EN (unsigned high-word correction).    |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package mul_pkg;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  localparam int MUL_CORE_LATENCY = 5;

`ifdef MUL_UNSIGNED_EN
  // Turns the signed core's high word into the unsigned / signed-unsigned one.
  function automatic logic [31:0] mul_hi_fix(input mul_op_e op, input logic [31:0] hi,
                                             input logic [31:0] a, input logic [31:0] b);
    logic [31:0] w_fix;
    case (op)
      OP_MULHU:  w_fix = (a[31] ? b : 32'd0) + (b[31] ? a : 32'd0);
      OP_MULHSU: w_fix = b[31] ? a : 32'd0;
      default:   w_fix = 32'd0;
    endcase
    return hi + w_fix;
  endfunction
`endif

endpackage
`default_nettype wire

// File: rtl/mul_result_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_result_fifo: synchronous FIFO with registered head, count, full, empty. |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mul_result_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [CNT_W-1:0] o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // Wraps explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_do_pop) r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_issue_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mul_issue_ctrl: credit-based issue/writeback around a fixed-latency,        |
// | non-stalling multiplier core. Optional macro: MUL_UNSIGNED_EN.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module mul_issue_ctrl
  import mul_pkg::*;
#(
  parameter int LATENCY = MUL_CORE_LATENCY,
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_op,
  input  logic [31:0]       in_a,
  input  logic [31:0]       in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [31:0]       mul_a,
  output logic [31:0]       mul_b,
  input  logic [63:0]       mul_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = $clog2(DEPTH + LATENCY + 1);
  localparam int ENT_W = 32 + TAG_W;

  typedef struct packed {
    logic             vld;
    mul_op_e          op;
    logic [TAG_W-1:0] tag;
`ifdef MUL_UNSIGNED_EN
    logic [31:0]      a;
    logic [31:0]      b;
`endif
  } dl_entry_t;

  dl_entry_t        r_dl [LATENCY];
  dl_entry_t        w_stage0;
  dl_entry_t        w_last;
  logic             w_accept;
  logic [SUM_W-1:0] w_inflight;
  logic [31:0]      w_hi;
  logic [31:0]      w_word;
  logic             w_pop;
  logic [ENT_W-1:0] w_head;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_fifo_full;
  logic             w_fifo_empty;

  assign mul_a    = in_a;
  assign mul_b    = in_b;
  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_stage0     = '0;
    w_stage0.vld = w_accept;
    w_stage0.op  = mul_op_e'(in_op);
    w_stage0.tag = in_tag;
`ifdef MUL_UNSIGNED_EN
    w_stage0.a   = in_a;
    w_stage0.b   = in_b;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) r_dl[i] <= '0;
    end else begin
      r_dl[0] <= w_stage0;
      for (int i = 1; i < LATENCY; i++) r_dl[i] <= r_dl[i-1];
    end
  end

  // Every op still in the delay line already owns a FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) w_inflight = w_inflight + SUM_W'(r_dl[i].vld);
  end

  assign in_ready = (SUM_W'(w_fifo_count) + w_inflight) < SUM_W'(DEPTH);

  always_comb begin
    w_last = r_dl[LATENCY-1];
`ifdef MUL_UNSIGNED_EN
    w_hi   = mul_hi_fix(w_last.op, mul_result[63:32], w_last.a, w_last.b);
`else
    w_hi   = mul_result[63:32];
`endif
    w_word = (w_last.op == OP_MUL) ? mul_result[31:0] : w_hi;
  end

  assign w_pop = out_valid && out_ready;

  mul_result_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_last.vld),
    .i_data  ({w_word, w_last.tag}),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign out_valid = !w_fifo_empty;
  assign out_data  = w_head[TAG_W +: 32];
  assign out_tag   = w_head[TAG_W-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(w_last.vld && w_fifo_full && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | tb_mul_issue_ctrl: directed self-checking bench with a 5-stage core model.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_mul_issue_ctrl;
  import mul_pkg::*;

  localparam int LAT   = 5;
  localparam int DEPTH = 8;
  localparam int TAG_W = 4;
  localparam int NVEC  = 11;

`ifdef MUL_UNSIGNED_EN
  localparam logic [31:0] EXP_HU   = 32'hFFFF_FFFE;
  localparam logic [31:0] EXP_HSU2 = 32'h0000_0001;
`else
  localparam logic [31:0] EXP_HU   = 32'h0000_0000;
  localparam logic [31:0] EXP_HSU2 = 32'hFFFF_FFFF;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_op = 2'b00;
  logic [31:0]      in_a = '0;
  logic [31:0]      in_b = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      mul_a;
  logic [31:0]      mul_b;
  logic [63:0]      mul_result;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;
  exp_t exp_q [$];

  logic [1:0]  v_op  [NVEC] = '{OP_MUL, OP_MULH, OP_MUL, OP_MULH, OP_MUL, OP_MULH,
                                OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_MULHSU};
  logic [31:0] v_a   [NVEC] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h0001_0000, 32'h0001_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFE,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
  logic [31:0] v_b   [NVEC] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h0001_0000, 32'h0001_0000, 32'd7, 32'd7,
                                32'hFFFF_FFFF, 32'd2, 32'h8000_0000};
  logic [31:0] v_exp [NVEC] = '{32'h0000_000F, 32'h0000_0000, 32'h0000_0001, 32'h4000_0000,
                                32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFF2, 32'hFFFF_FFFF,
                                EXP_HU, 32'hFFFF_FFFF, EXP_HSU2};

  always #5 clk = ~clk;

  mul_issue_ctrl #(
    .LATENCY (LAT),
    .DEPTH   (DEPTH),
    .TAG_W   (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_result (mul_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_tag    (out_tag)
  );

  // Signed 32x32 core with LAT register cuts; it never resets or stalls.
  logic [63:0] core_pipe [LAT];
  always @(posedge clk) begin
    core_pipe[0] <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
    for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
  end
  assign mul_result = core_pipe[LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [31:0] data, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.data = data;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input logic [31:0] exp, input bit track);
    int w;
    w = 0;
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      step();
      w++;
    end
    if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
    if (track) expect_out(exp, tag);
    step();
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      step();
      w++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    step();
    step();
    check({name, "_idle"}, 64'(out_valid), 64'd0);
  endtask

  // Scoreboard: every pop must match the next hand-computed result in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid && out_ready), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.data));
        check("out_tag", 64'(out_tag), 64'(e.tag));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last, nv, stalls, idx, n_acc, w;
    logic seen_valid, seen_not_ready;

    rst = 1'b1;
    repeat (3) step();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    rst = 1'b0;
    step();

    // Single op on an idle pipe: out_valid appears LAT+1 cycles after accept.
    out_ready = 1'b1;
    send(OP_MUL, 32'd3, 32'd5, 4'hA, 32'h0000_000F, 1'b1);
    in_valid = 1'b0;
    repeat (4) step();
    check("lat_t5_idle", 64'(out_valid), 64'd0);
    step();
    check("lat_t6_valid", 64'(out_valid), 64'd1);
    check("lat_t6_data", 64'(out_data), 64'h0000_000F);
    check("lat_t6_tag", 64'(out_tag), 64'hA);
    drain("single");

    // Back-to-back table: no stalls, results contiguous and in order.
    first = -1; last = -1; nv = 0; stalls = 0; idx = 0;
    for (int c = 0; c < 30; c++) begin
      if (idx < NVEC) begin
        in_valid = 1'b1;
        in_op    = v_op[idx];
        in_a     = v_a[idx];
        in_b     = v_b[idx];
        in_tag   = TAG_W'(idx);
      end else begin
        in_valid = 1'b0;
      end
      if (out_valid) begin
        nv++;
        if (first < 0) first = c;
        last = c;
      end
      if (in_valid && in_ready) begin
        expect_out(v_exp[idx], TAG_W'(idx));
        idx++;
      end else if (in_valid) begin
        stalls++;
      end
      step();
    end
    check("b2b_stalls", 64'(stalls), 64'd0);
    check("b2b_first", 64'(first), 64'd6);
    check("b2b_count", 64'(nv), 64'(NVEC));
    check("b2b_contig", 64'(last - first), 64'(NVEC - 1));
    drain("b2b");

    // Backpressure: exactly DEPTH credits, then refill one per pop.
    out_ready = 1'b0;
    n_acc = 0;
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; in_op = OP_MUL; in_a = 32'(n_acc + 1); in_b = 32'd7;
      in_tag = TAG_W'(n_acc);
      if (in_ready) begin
        expect_out(32'((n_acc + 1) * 7), TAG_W'(n_acc));
        n_acc++;
      end
      step();
    end
    check("bp_accepted", 64'(n_acc), 64'd8);
    check("bp_in_ready_low", 64'(in_ready), 64'd0);
    check("bp_head_valid", 64'(out_valid), 64'd1);
    check("bp_head_tag", 64'(out_tag), 64'd0);
    check("bp_head_data", 64'(out_data), 64'd7);
    out_ready = 1'b1;
    w = 0;
    while (n_acc < 16 && w < 60) begin
      in_valid = 1'b1; in_op = OP_MUL; in_a = 32'(n_acc + 1); in_b = 32'd7;
      in_tag = TAG_W'(n_acc);
      if (in_ready) begin
        expect_out(32'((n_acc + 1) * 7), TAG_W'(n_acc));
        n_acc++;
      end
      step();
      w++;
    end
    in_valid = 1'b0;
    check("bp_refill", 64'(n_acc), 64'd16);
    drain("bp");

    // Reset with three ops still in the delay line.
    send(OP_MUL, 32'd11, 32'd13, 4'd1, 32'd0, 1'b0);
    send(OP_MULH, 32'hFFFF_FFFF, 32'd2, 4'd2, 32'd0, 1'b0);
    send(OP_MUL, 32'd6, 32'd6, 4'd3, 32'd0, 1'b0);
    in_valid = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_out_valid", 64'(out_valid), 64'd0);
    check("rstmid_in_ready", 64'(in_ready), 64'd1);
    check("rstmid_out_data", 64'(out_data), 64'd0);
    seen_valid = 1'b0;
    seen_not_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      seen_valid     = seen_valid | out_valid;
      seen_not_ready = seen_not_ready | !in_ready;
      step();
    end
    check("rstmid_no_stale", 64'(seen_valid), 64'd0);
    check("rstmid_ready_held", 64'(seen_not_ready), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
